// File: rtl/connect_n_checker.sv
// Win detector for an N-in-a-row drop game: after each move it walks the four
// axes through the placed piece using one synchronous board read port.
module connect_n_checker #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3,
    parameter int LEN_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROW_W-1:0] move_row,
    input  logic [COL_W-1:0] move_col,
    input  logic [1:0]       player,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    output logic             rd_en,
    input  logic [1:0]       rd_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic [1:0]       win_axis,
    output logic [LEN_W-1:0] run_len
);

    // Cursor arithmetic is kept wide enough that move + step never wraps.
    localparam int IW = ((ROW_W > COL_W) ? ROW_W : COL_W) + LEN_W + 2;

    localparam logic signed [IW-1:0] ZERO_S   = IW'(0);
    localparam logic signed [IW-1:0] ROWS_S   = IW'(ROWS);
    localparam logic signed [IW-1:0] COLS_S   = IW'(COLS);
    localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]     STEP_MAX = LEN_W'(WIN_LEN - 1);
    localparam logic [LEN_W-1:0]     WIN_CNT  = LEN_W'(WIN_LEN);

    localparam logic [1:0] D_ZERO = 2'd0;
    localparam logic [1:0] D_POS  = 2'd1;
    localparam logic [1:0] D_NEG  = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        AXIS_INIT = 3'd1,
        ADDR      = 3'd2,
        CMP       = 3'd3,
        DIR_END   = 3'd4,
        AXIS_EVAL = 3'd5,
        FINISH    = 3'd6
    } state_t;

    function automatic logic [1:0] flip_delta(input logic [1:0] d, input logic neg);
        logic [1:0] r;
        if (neg) begin
            case (d)
                D_POS:   r = D_NEG;
                D_NEG:   r = D_POS;
                default: r = d;
            endcase
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [1:0] row_delta(input logic [1:0] axis);
        logic [1:0] r;
        case (axis)
            2'd0, 2'd2: r = D_POS;
            2'd3:       r = D_NEG;
            default:    r = D_ZERO;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] col_delta(input logic [1:0] axis);
        logic [1:0] r;
        case (axis)
            2'd0:    r = D_ZERO;
            default: r = D_POS;
        endcase
        return r;
    endfunction

    function automatic logic signed [IW-1:0] apply_delta(input logic signed [IW-1:0] base,
                                                         input logic signed [IW-1:0] stp,
                                                         input logic [1:0] d);
        logic signed [IW-1:0] r;
        case (d)
            D_POS:   r = base + stp;
            D_NEG:   r = base - stp;
            default: r = base;
        endcase
        return r;
    endfunction

    state_t               state_r, state_s;
    logic [ROW_W-1:0]     mrow_r;
    logic [COL_W-1:0]     mcol_r;
    logic [1:0]           player_r;
    logic [1:0]           axis_r, axis_s;
    logic                 dir_r, dir_s;
    logic [LEN_W-1:0]     step_r, step_s;
    logic [LEN_W-1:0]     cnt_r, cnt_s;
    logic [1:0]           winner_r, winner_s;
    logic [1:0]           win_axis_r, win_axis_s;
    logic [LEN_W-1:0]     run_len_r, run_len_s;
    logic                 probe_ok_r, probe_ok_s;
    logic signed [IW-1:0] cur_row_s, cur_col_s;
    logic                 rd_en_r;
    logic [ROW_W-1:0]     rd_row_r;
    logic [COL_W-1:0]     rd_col_r;
    logic                 busy_r, done_r;

    // Next-state and datapath update of the walk controller.
    always_comb begin
        state_s    = state_r;
        axis_s     = axis_r;
        dir_s      = dir_r;
        step_s     = step_r;
        cnt_s      = cnt_r;
        winner_s   = winner_r;
        win_axis_s = win_axis_r;
        run_len_s  = run_len_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    winner_s  = 2'b00;
                    run_len_s = '0;
                    axis_s    = 2'd0;
                    if (player == 2'b00) begin
                        state_s = FINISH;
                    end else begin
                        state_s = AXIS_INIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            AXIS_INIT: begin
                cnt_s   = LEN_ONE;
                dir_s   = 1'b0;
                step_s  = LEN_ONE;
                state_s = ADDR;
            end
            ADDR: begin
                if (probe_ok_r) begin
                    state_s = CMP;
                end else begin
                    state_s = DIR_END;
                end
            end
            CMP: begin
                if (rd_data == player_r) begin
                    cnt_s   = cnt_r + LEN_ONE;
                    step_s  = step_r + LEN_ONE;
                    state_s = ADDR;
                end else begin
                    state_s = DIR_END;
                end
            end
            DIR_END: begin
                if (!dir_r) begin
                    dir_s   = 1'b1;
                    step_s  = LEN_ONE;
                    state_s = ADDR;
                end else begin
                    state_s = AXIS_EVAL;
                end
            end
            AXIS_EVAL: begin
                if (cnt_r >= WIN_CNT) begin
                    winner_s   = player_r;
                    win_axis_s = axis_r;
                    run_len_s  = cnt_r;
                    state_s    = FINISH;
                end else begin
                    if (cnt_r > run_len_r) begin
                        run_len_s = cnt_r;
                    end else begin
                        run_len_s = run_len_r;
                    end
                    if (axis_r == 2'd3) begin
                        state_s = FINISH;
                    end else begin
                        axis_s  = axis_r + 2'd1;
                        state_s = AXIS_INIT;
                    end
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Cursor for the probe about to be issued, so the read strobe can be registered.
    always_comb begin
        cur_row_s  = apply_delta($signed({{(IW-ROW_W){1'b0}}, mrow_r}),
                                 $signed({{(IW-LEN_W){1'b0}}, step_s}),
                                 flip_delta(row_delta(axis_s), dir_s));
        cur_col_s  = apply_delta($signed({{(IW-COL_W){1'b0}}, mcol_r}),
                                 $signed({{(IW-LEN_W){1'b0}}, step_s}),
                                 flip_delta(col_delta(axis_s), dir_s));
        probe_ok_s = (cur_row_s >= ZERO_S) && (cur_row_s < ROWS_S) &&
                     (cur_col_s >= ZERO_S) && (cur_col_s < COLS_S) &&
                     (step_s <= STEP_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            mrow_r     <= '0;
            mcol_r     <= '0;
            player_r   <= 2'b00;
            axis_r     <= 2'd0;
            dir_r      <= 1'b0;
            step_r     <= '0;
            cnt_r      <= '0;
            winner_r   <= 2'b00;
            win_axis_r <= 2'd0;
            run_len_r  <= '0;
            probe_ok_r <= 1'b0;
            rd_en_r    <= 1'b0;
            rd_row_r   <= '0;
            rd_col_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            axis_r     <= axis_s;
            dir_r      <= dir_s;
            step_r     <= step_s;
            cnt_r      <= cnt_s;
            winner_r   <= winner_s;
            win_axis_r <= win_axis_s;
            run_len_r  <= run_len_s;
            probe_ok_r <= probe_ok_s;
            if ((state_r == IDLE) && start) begin
                mrow_r   <= move_row;
                mcol_r   <= move_col;
                player_r <= player;
            end
            // Only in-bounds cursors ever reach the address outputs.
            rd_en_r <= (state_s == ADDR) && probe_ok_s;
            if ((state_s == ADDR) && probe_ok_s) begin
                rd_row_r <= cur_row_s[ROW_W-1:0];
                rd_col_r <= cur_col_s[COL_W-1:0];
            end
            busy_r <= (state_s != IDLE);
            done_r <= (state_r == FINISH);
        end
    end

    assign rd_en    = rd_en_r;
    assign rd_row   = rd_row_r;
    assign rd_col   = rd_col_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign winner   = winner_r;
    assign win_axis = win_axis_r;
    assign run_len  = run_len_r;

endmodule

// File: tb/tb_connect_n_checker.sv
// Bench for connect_n_checker: a 6x7/4 and an 8x8/5 instance, each backed by a
// board array, checked against a direct line-counting model of the game rules.
module tb_connect_n_checker;

    logic       clk;
    logic       rst_n;
    logic       start_a  [2];
    logic [2:0] mrow_a   [2];
    logic [2:0] mcol_a   [2];
    logic [1:0] player_a [2];
    logic [2:0] rd_row_a [2];
    logic [2:0] rd_col_a [2];
    logic       rd_en_a  [2];
    logic [1:0] rdd_a    [2];
    logic       busy_a   [2];
    logic       done_a   [2];
    logic [1:0] winner_a [2];
    logic [1:0] axis_a   [2];
    logic [2:0] rl0;
    logic [3:0] rl1;

    logic [1:0] board [2][8][8];
    int checks = 0;
    int errors = 0;
    int issued [2];
    int completed [2];
    int nreads [2];
    int exp_w [2];
    int exp_ax [2];
    int exp_rl [2];
    int exp_nr [2];

    connect_n_checker #(.ROWS(6), .COLS(7), .WIN_LEN(4), .ROW_W(3), .COL_W(3), .LEN_W(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .move_row(mrow_a[0]), .move_col(mcol_a[0]),
        .player(player_a[0]), .rd_row(rd_row_a[0]), .rd_col(rd_col_a[0]), .rd_en(rd_en_a[0]),
        .rd_data(rdd_a[0]), .busy(busy_a[0]), .done(done_a[0]), .winner(winner_a[0]),
        .win_axis(axis_a[0]), .run_len(rl0));

    connect_n_checker #(.ROWS(8), .COLS(8), .WIN_LEN(5), .ROW_W(3), .COL_W(3), .LEN_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .move_row(mrow_a[1]), .move_col(mcol_a[1]),
        .player(player_a[1]), .rd_row(rd_row_a[1]), .rd_col(rd_col_a[1]), .rd_en(rd_en_a[1]),
        .rd_data(rdd_a[1]), .busy(busy_a[1]), .done(done_a[1]), .winner(winner_a[1]),
        .win_axis(axis_a[1]), .run_len(rl1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nrows(input int inst); return (inst != 0) ? 8 : 6; endfunction
    function automatic int ncols(input int inst); return (inst != 0) ? 8 : 7; endfunction
    function automatic int wlen(input int inst);  return (inst != 0) ? 5 : 4; endfunction
    function automatic int rlen_of(input int inst); return (inst != 0) ? int'(rl1) : int'(rl0); endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous board RAM with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rdd_a[i] <= rd_en_a[i] ? board[i][rd_row_a[i]][rd_col_a[i]] : 2'b00;
        end
    end

    // Reference: count same-owner cells outward along each line, at most WIN_LEN-1 per side.
    function automatic void model(input int inst, input int r, input int c, input int p,
                                  output int w, output int ax, output int rl, output int nr);
        int dr, dc, cnt, rr, cc, wl;
        bit stop;
        wl = wlen(inst);
        w = 0; ax = 0; rl = 0; nr = 0;
        if (p == 0) return;
        for (int a = 0; a < 4; a++) begin
            dr = (a == 0 || a == 2) ? 1 : ((a == 3) ? -1 : 0);
            dc = (a == 0) ? 0 : 1;
            cnt = 1;
            for (int s = 1; s >= -1; s -= 2) begin
                stop = 1'b0;
                for (int k = 1; k < wl; k++) begin
                    if (!stop) begin
                        rr = r + s * k * dr;
                        cc = c + s * k * dc;
                        if (rr < 0 || rr >= nrows(inst) || cc < 0 || cc >= ncols(inst)) begin
                            stop = 1'b1;
                        end else begin
                            nr++;
                            if (int'(board[inst][rr][cc]) != p) stop = 1'b1;
                            else cnt++;
                        end
                    end
                end
            end
            if (cnt > rl) rl = cnt;
            if (cnt >= wl) begin
                w = p; ax = a; rl = cnt;
                return;
            end
        end
    endfunction

    // Compare process: address range on every read, full result on every done.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (start_a[i] && !busy_a[i]) nreads[i] = 0;
            if (rd_en_a[i]) begin
                nreads[i]++;
                chk("rd_addr_in_range",
                    int'(int'(rd_row_a[i]) < nrows(i) && int'(rd_col_a[i]) < ncols(i)), 1);
            end
            if (done_a[i]) begin
                chk("done_expected", int'(issued[i] != completed[i]), 1);
                if (issued[i] != completed[i]) begin
                    chk("winner", int'(winner_a[i]), exp_w[i]);
                    chk("run_len", rlen_of(i), exp_rl[i]);
                    if (exp_w[i] != 0) chk("win_axis", int'(axis_a[i]), exp_ax[i]);
                    chk("read_count", nreads[i], exp_nr[i]);
                    chk("busy_low_at_done", int'(busy_a[i]), 0);
                    completed[i]++;
                end
            end
        end
    end

    task automatic clear_board(input int inst, input logic [1:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                board[inst][r][c] = v;
    endtask

    task automatic arm(input int inst, input int r, input int c, input int p);
        int w, ax, rl, nr;
        model(inst, r, c, p, w, ax, rl, nr);
        exp_w[inst] = w; exp_ax[inst] = ax; exp_rl[inst] = rl; exp_nr[inst] = nr;
        issued[inst]++;
    endtask

    task automatic issue(input int inst, input int r, input int c, input int p);
        @(posedge clk); #1;
        mrow_a[inst] = 3'(r); mcol_a[inst] = 3'(c); player_a[inst] = 2'(p);
        start_a[inst] = 1'b1;
        @(posedge clk); #1;
        start_a[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, output int lat);
        lat = 1;
        while (!done_a[inst] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_within_limit", int'(done_a[inst]), 1);
        if (!done_a[inst]) issued[inst]--;
    endtask

    task automatic run_move(input int inst, input int r, input int c, input int p);
        int lat, bound;
        bound = 4 * (4 * (wlen(inst) - 1) + 4) + 1;
        arm(inst, r, c, p);
        issue(inst, r, c, p);
        wait_done(inst, lat);
        chk("latency_bound", int'(lat <= bound), 1);
        if (p == 0) chk("latency_player0", lat, 2);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pin(input int inst, input int r, input int c, input int p,
                       input int w, input int ax, input int rl, input int nr);
        int mw, max_, mrl, mnr;
        model(inst, r, c, p, mw, max_, mrl, mnr);
        chk("model_winner", mw, w);
        if (w != 0) chk("model_axis", max_, ax);
        chk("model_run_len", mrl, rl);
        chk("model_reads", mnr, nr);
        run_move(inst, r, c, p);
    endtask

    task automatic chk_reset(input int inst);
        chk("rst_busy", int'(busy_a[inst]), 0);
        chk("rst_done", int'(done_a[inst]), 0);
        chk("rst_winner", int'(winner_a[inst]), 0);
        chk("rst_win_axis", int'(axis_a[inst]), 0);
        chk("rst_run_len", rlen_of(inst), 0);
        chk("rst_rd_en", int'(rd_en_a[inst]), 0);
        chk("rst_rd_row", int'(rd_row_a[inst]), 0);
        chk("rst_rd_col", int'(rd_col_a[inst]), 0);
    endtask

    initial begin
        int k, lat, p, r, c, inst;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0; mrow_a[i] = 3'd0; mcol_a[i] = 3'd0; player_a[i] = 2'b00;
            issued[i] = 0; completed[i] = 0; nreads[i] = 0;
            exp_w[i] = 0; exp_ax[i] = 0; exp_rl[i] = 0; exp_nr[i] = 0;
            clear_board(i, 2'b00);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Empty board, bottom-row move.
        board[0][0][3] = 2'b01;
        pin(0, 0, 3, 1, 0, 0, 1, 5);

        // Vertical four in column 2.
        clear_board(0, 2'b00);
        for (int i = 0; i < 4; i++) board[0][i][2] = 2'b01;
        pin(0, 3, 2, 1, 1, 0, 4, 4);

        // Horizontal four on row 0, (0,4) empty.
        clear_board(0, 2'b00);
        for (int i = 0; i < 4; i++) board[0][0][i] = 2'b10;
        pin(0, 0, 2, 2, 2, 1, 4, 5);

        // Diagonal four, move in the middle.
        clear_board(0, 2'b00);
        clear_board(1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            board[0][i][i] = 2'b01;
            board[1][i][i] = 2'b01;
        end
        pin(0, 1, 1, 1, 1, 2, 4, 8);
        pin(1, 1, 1, 1, 0, 0, 4, 10);

        // Corner move against a board full of the opponent.
        clear_board(0, 2'b10);
        board[0][5][6] = 2'b01;
        pin(0, 5, 6, 1, 0, 0, 1, 3);

        // Empty player: no reads, done two cycles after start.
        pin(0, 2, 2, 0, 0, 0, 0, 0);

        // A second start while busy must not disturb the latched move.
        clear_board(0, 2'b00);
        for (int i = 0; i < 4; i++) board[0][i][2] = 2'b01;
        arm(0, 3, 2, 1);
        issue(0, 3, 2, 1);
        chk("busy_after_start", int'(busy_a[0]), 1);
        issue(0, 0, 0, 2);
        wait_done(0, lat);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset during a compare cycle aborts the check.
        clear_board(0, 2'b00);
        board[0][2][3] = 2'b01;
        arm(0, 2, 3, 1);
        issue(0, 2, 3, 1);
        k = 0;
        while (!rd_en_a[0] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reached_read", int'(rd_en_a[0]), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        issued[0]--;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_move(0, 2, 3, 1);

        // Random boards with a bias towards the moving player.
        for (int n = 0; n < 60; n++) begin
            inst = n % 2;
            p = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2));
            r = int'($urandom_range(0, nrows(inst) - 1));
            c = int'($urandom_range(0, ncols(inst) - 1));
            for (int rr = 0; rr < 8; rr++)
                for (int cc = 0; cc < 8; cc++)
                    board[inst][rr][cc] = ($urandom_range(0, 2) == 0) ? 2'b00 :
                                          (($urandom_range(0, 2) != 0) ? 2'((p == 0) ? 1 : p)
                                                                       : 2'((p == 2) ? 1 : 2));
            board[inst][r][c] = 2'(p);
            run_move(inst, r, c, p);
        end

        for (int i = 0; i < 2; i++) chk("all_checks_completed", completed[i], issued[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
